// File: rtl/sv32_ptw.sv
// Sv32 page-table walker with a small fully-associative TLB in front of dmem.
// Leaf permission checks run in RESP so TLB hits and fresh walks share one path.
module sv32_ptw #(
   parameter int TLB_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_va,
   input  logic        req_is_load,
   input  logic        req_is_store,
   input  logic        req_is_inst,
   input  logic [31:0] csr_satp,
   input  logic [1:0]  priv,
   input  logic        sstatus_sum,
   input  logic        sfence,
   output logic        resp_valid,
   output logic [31:0] resp_pa,
   output logic        resp_fault,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);
   localparam int IW = $clog2(TLB_ENTRIES);

   typedef enum logic [1:0] {IDLE, L1, L0, RESP} state_t;

   typedef struct packed {
      logic [9:0]  vpn1;
      logic [9:0]  vpn0;
      logic        sup;
      logic [19:0] ppn;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        d;
   } tlb_t;

   state_t                 state;
   tlb_t                   tlb [TLB_ENTRIES];
   logic [TLB_ENTRIES-1:0] tlb_v;
   logic [IW-1:0]          rr;
   logic [31:0]            satp_q;
   logic [31:0]            va;
   logic                   is_load, is_store, is_inst;
   logic [1:0]             prv;
   logic                   sum;
   logic                   bypass, walk_fault, do_insert, no_insert;
   tlb_t                   leaf;

   logic                   flush;
   logic [TLB_ENTRIES-1:0] hit_vec, ins_vec;
   logic [IW-1:0]          hit_idx, ins_idx;
   logic                   hit;
   tlb_t                   pte_leaf;
   logic                   pte_bad, pte_ptr;
   logic                   perm_fault, fault;
   logic [31:0]            pa;
   logic                   unused;

   assign unused = &{1'b0, mem_resp_data[31:30], mem_resp_data[9:8], mem_resp_data[6:5]};

   // Any satp write invalidates cached translations, same as sfence.
   assign flush = sfence | (csr_satp != satp_q);

   always_comb begin
      hit_vec = '0;
      ins_vec = '0;
      hit_idx = '0;
      ins_idx = rr;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         hit_vec[i] = tlb_v[i] && tlb[i].vpn1 == req_va[31:22] &&
                      (tlb[i].sup || tlb[i].vpn0 == req_va[21:12]);
         ins_vec[i] = tlb_v[i] && tlb[i].vpn1 == leaf.vpn1 && tlb[i].sup == leaf.sup &&
                      (leaf.sup || tlb[i].vpn0 == leaf.vpn0);
      end
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) hit_idx = IW'(i);
         if (ins_vec[i]) ins_idx = IW'(i);
      end
      hit = |hit_vec && !flush;
   end

   always_comb begin
      pte_leaf      = '0;
      pte_leaf.vpn1 = va[31:22];
      pte_leaf.vpn0 = va[21:12];
      pte_leaf.sup  = (state == L1);
      pte_leaf.ppn  = mem_resp_data[29:10];
      pte_leaf.u    = mem_resp_data[4];
      pte_leaf.x    = mem_resp_data[3];
      pte_leaf.w    = mem_resp_data[2];
      pte_leaf.r    = mem_resp_data[1];
      pte_leaf.d    = mem_resp_data[7];
      pte_bad       = !mem_resp_data[0] || (mem_resp_data[2] && !mem_resp_data[1]);
      pte_ptr       = !mem_resp_data[1] && !mem_resp_data[2] && !mem_resp_data[3];
   end

   always_comb begin
      perm_fault = (!leaf.u && prv == 2'd0) ||
                   (leaf.u && prv == 2'd1 && !sum) ||
                   (is_inst && !leaf.x) ||
                   (is_load && !leaf.r) ||
                   (is_store && !(leaf.w && leaf.d));
      fault = !bypass && (walk_fault || perm_fault);
      if (bypass)        pa = va;
      else if (leaf.sup) pa = {leaf.ppn[19:10], va[21:0]};
      else               pa = {leaf.ppn, va[11:0]};
   end

   always_ff @(posedge clk) begin
      satp_q <= csr_satp;
      if (rst) begin
         state         <= IDLE;
         tlb_v         <= '0;
         rr            <= '0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_pa       <= '0;
         resp_fault    <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         bypass        <= 1'b0;
         walk_fault    <= 1'b0;
         do_insert     <= 1'b0;
         no_insert     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               va         <= req_va;
               is_load    <= req_is_load;
               is_store   <= req_is_store;
               is_inst    <= req_is_inst;
               prv        <= priv;
               sum        <= sstatus_sum;
               req_ready  <= 1'b0;
               walk_fault <= 1'b0;
               do_insert  <= 1'b0;
               no_insert  <= 1'b0;
               bypass     <= !csr_satp[31] || priv == 2'd3;
               if (!csr_satp[31] || priv == 2'd3) begin
                  state <= RESP;
               end else if (hit) begin
                  leaf  <= tlb[hit_idx];
                  state <= RESP;
               end else begin
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {csr_satp[19:0], req_va[31:22], 2'b00};
                  state         <= L1;
               end
            end
            L1, L0: begin
               if (flush) no_insert <= 1'b1;
               if (mem_resp_valid) begin
                  if (pte_bad || (pte_ptr && state == L0)) begin
                     walk_fault    <= 1'b1;
                     mem_req_valid <= 1'b0;
                     state         <= RESP;
                  end else if (pte_ptr) begin
                     // Request stays asserted; only the address moves to the L0 table.
                     mem_req_addr <= {mem_resp_data[29:10], va[21:12], 2'b00};
                     state        <= L0;
                  end else begin
                     leaf          <= pte_leaf;
                     mem_req_valid <= 1'b0;
                     state         <= RESP;
                     if (state == L1 && mem_resp_data[19:10] != 10'd0) walk_fault <= 1'b1;
                     else                                               do_insert  <= 1'b1;
                  end
               end
            end
            RESP: begin
               resp_valid <= 1'b1;
               resp_fault <= fault;
               resp_pa    <= fault ? 32'd0 : pa;
               req_ready  <= 1'b1;
               do_insert  <= 1'b0;
               state      <= IDLE;
               if (do_insert && !no_insert && !flush) begin
                  tlb[ins_idx]   <= leaf;
                  tlb_v[ins_idx] <= 1'b1;
                  if (ins_vec == '0) rr <= rr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (flush) tlb_v <= '0;
      end
   end
endmodule

// File: tb/tb_sv32_ptw.sv
// Directed bench for sv32_ptw: page tables held in an associative array,
// PTE reads answered one cycle after each request.
module tb_sv32_ptw;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_va;
   logic        req_is_load, req_is_store, req_is_inst;
   logic [31:0] csr_satp;
   logic [1:0]  priv;
   logic        sstatus_sum, sfence;
   logic        resp_valid;
   logic [31:0] resp_pa;
   logic        resp_fault;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int n_chk = 0;
   int n_fail = 0;
   int n_reads = 0;
   logic [31:0] rd_log [4];
   logic [31:0] block_addr = 32'hFFFF_FFFF;
   logic [31:0] mem [logic [31:0]];

   sv32_ptw #(.TLB_ENTRIES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
      .req_is_load(req_is_load), .req_is_store(req_is_store), .req_is_inst(req_is_inst),
      .csr_satp(csr_satp), .priv(priv), .sstatus_sum(sstatus_sum), .sfence(sfence),
      .resp_valid(resp_valid), .resp_pa(resp_pa), .resp_fault(resp_fault),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Memory model: answer every other cycle while a request is held.
   always @(negedge clk) begin
      if (rst || mem_resp_valid) begin
         mem_resp_valid = 1'b0;
      end else if (mem_req_valid && mem_req_addr != block_addr) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'd0;
         if (n_reads < 4) rd_log[n_reads] = mem_req_addr;
         n_reads++;
      end
   end

   // kind: 0=load 1=store 2=inst
   task automatic xlate(input logic [31:0] va, input int kind, input logic sf,
                        output logic [31:0] pa, output logic flt, output int cyc, output int reads);
      bit got;
      @(negedge clk);
      n_reads      = 0;
      req_valid    = 1'b1;
      req_va       = va;
      req_is_load  = (kind == 0);
      req_is_store = (kind == 1);
      req_is_inst  = (kind == 2);
      sfence       = sf;
      @(posedge clk); #1;
      req_valid = 1'b0;
      sfence    = 1'b0;
      cyc = 1;
      got = 0;
      while (!got && cyc < 40) begin
         if (resp_valid) got = 1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!got) chk("resp_timeout", 32'd0, 32'd1);
      pa    = resp_pa;
      flt   = resp_fault;
      reads = n_reads;
   endtask

   logic [31:0] pa;
   logic        flt;
   int          cyc, reads, seen;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_va = '0;
      req_is_load = 1'b1; req_is_store = 1'b0; req_is_inst = 1'b0;
      csr_satp = 32'd0; priv = 2'd1; sstatus_sum = 1'b0; sfence = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0;

      mem[32'h0001_0004] = 32'h0000_0401;          // L1 pointer -> L0 table at 0x1000
      mem[32'h0000_1014] = 32'h0002_00CF;          // vpn0=5: RWX D, U=0, ppn 0x80
      mem[32'h0000_1018] = 32'h0002_0447;          // vpn0=6: RW, D=0, ppn 0x81
      mem[32'h0000_101C] = 32'h0002_08CF;          // vpn0=7: RWX, U=0, ppn 0x82
      mem[32'h0000_1020] = 32'h0002_0CDF;          // vpn0=8: RWX, U=1, ppn 0x83
      mem[32'h0001_0008] = 32'h0040_00CF;          // superpage, ppn 0x1000
      mem[32'h0001_000C] = 32'h0040_04CF;          // misaligned superpage
      for (int v = 10; v < 14; v++) mem[32'h1000 + 32'(4 * v)] = ((32'h90 + 32'(v)) << 10) | 32'hCF;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_pa", resp_pa, 32'd0);
      chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
      chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk); rst = 1'b0;

      // Bare mode and M-mode pass through
      xlate(32'h0000_1234, 0, 1'b0, pa, flt, cyc, reads);
      chk("bare_pa", pa, 32'h0000_1234);
      chk("bare_fault", {31'd0, flt}, 32'd0);
      chk("bare_reads", reads, 0);
      chk("bare_lat", cyc, 2);
      csr_satp = 32'h8000_0010; priv = 2'd3;
      xlate(32'hDEAD_0123, 0, 1'b0, pa, flt, cyc, reads);
      chk("m_pa", pa, 32'hDEAD_0123);
      chk("m_reads", reads, 0);
      priv = 2'd1;

      // Two-level walk
      xlate(32'h0040_5ABC, 0, 1'b0, pa, flt, cyc, reads);
      chk("walk_pa", pa, 32'h0008_0ABC);
      chk("walk_fault", {31'd0, flt}, 32'd0);
      chk("walk_reads", reads, 2);
      chk("walk_addr1", rd_log[0], 32'h0001_0004);
      chk("walk_addr0", rd_log[1], 32'h0000_1014);

      // Hit, then flushes of each kind
      xlate(32'h0040_5ABC, 0, 1'b0, pa, flt, cyc, reads);
      chk("hit_pa", pa, 32'h0008_0ABC);
      chk("hit_reads", reads, 0);
      chk("hit_lat", cyc, 2);
      @(negedge clk); sfence = 1'b1;
      @(negedge clk); sfence = 1'b0;
      xlate(32'h0040_5ABC, 0, 1'b0, pa, flt, cyc, reads);
      chk("sfence_reads", reads, 2);
      chk("sfence_pa", pa, 32'h0008_0ABC);
      xlate(32'h0040_5ABC, 0, 1'b1, pa, flt, cyc, reads);
      chk("sfence_req_reads", reads, 2);
      @(negedge clk); csr_satp = 32'h8040_0010;
      xlate(32'h0040_5ABC, 1, 1'b0, pa, flt, cyc, reads);
      chk("satp_flush_reads", reads, 2);
      chk("store_ok_fault", {31'd0, flt}, 32'd0);

      // Permission faults
      xlate(32'h0040_6000, 1, 1'b0, pa, flt, cyc, reads);
      chk("store_d0_fault", {31'd0, flt}, 32'd1);
      chk("store_d0_pa", pa, 32'd0);
      priv = 2'd0;
      xlate(32'h0040_7010, 2, 1'b0, pa, flt, cyc, reads);
      chk("u_fetch_fault", {31'd0, flt}, 32'd1);
      priv = 2'd1;
      xlate(32'h0040_8044, 0, 1'b0, pa, flt, cyc, reads);
      chk("sum0_fault", {31'd0, flt}, 32'd1);
      sstatus_sum = 1'b1;
      xlate(32'h0040_8044, 0, 1'b0, pa, flt, cyc, reads);
      chk("sum1_fault", {31'd0, flt}, 32'd0);
      chk("sum1_pa", pa, 32'h0008_3044);
      chk("sum1_reads", reads, 0);
      sstatus_sum = 1'b0;

      // Superpages
      xlate(32'h0081_2345, 0, 1'b0, pa, flt, cyc, reads);
      chk("super_pa", pa, 32'h0101_2345);
      chk("super_reads", reads, 1);
      xlate(32'h00BF_FFFC, 0, 1'b0, pa, flt, cyc, reads);
      chk("super_hit_pa", pa, 32'h013F_FFFC);
      chk("super_hit_reads", reads, 0);
      xlate(32'h00C0_0000, 0, 1'b0, pa, flt, cyc, reads);
      chk("misalign_fault", {31'd0, flt}, 32'd1);
      chk("misalign_pa", pa, 32'd0);
      xlate(32'h00C0_0000, 0, 1'b0, pa, flt, cyc, reads);
      chk("misalign_no_insert", reads, 1);

      // Reset while L0 read is outstanding
      block_addr = 32'h0000_1024;
      @(negedge clk);
      req_valid = 1'b1; req_va = 32'h0040_9000;
      req_is_load = 1'b1; req_is_store = 1'b0; req_is_inst = 1'b0;
      @(posedge clk); #1; req_valid = 1'b0;
      cyc = 0;
      while (!(mem_req_valid && mem_req_addr == 32'h0000_1024) && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      chk("l0_reached", {31'd0, cyc < 20}, 32'd1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("rst_walk_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_walk_memreq", {31'd0, mem_req_valid}, 32'd0);
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      chk("rst_walk_no_resp", seen, 0);
      block_addr = 32'hFFFF_FFFF;
      xlate(32'h0040_5ABC, 0, 1'b0, pa, flt, cyc, reads);
      chk("rst_tlb_empty", reads, 2);

      // Round-robin eviction: four more pages push the first one out
      for (int v = 10; v < 14; v++) begin
         xlate(32'h0040_0000 | 32'(v << 12), 0, 1'b0, pa, flt, cyc, reads);
         chk("fill_reads", reads, 2);
      end
      xlate(32'h0040_D00C, 0, 1'b0, pa, flt, cyc, reads);
      chk("fill_last_hit", reads, 0);
      chk("fill_last_pa", pa, 32'h0009_D00C);
      xlate(32'h0040_A000, 0, 1'b0, pa, flt, cyc, reads);
      chk("fill_first_hit", reads, 0);
      xlate(32'h0040_5ABC, 0, 1'b0, pa, flt, cyc, reads);
      chk("evicted_rewalk", reads, 2);
      chk("evicted_pa", pa, 32'h0008_0ABC);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
